sram_bus_arbiter: RTL and testbench

//  Shares one SRAM-like memory port between the instruction-fetch requester (PC/IF stage) and the

---
 rtl/cpu_bus_pkg.sv | 20 ++
 rtl/owner_fifo.sv | 55 +++++
 rtl/sram_bus_arbiter.sv | 137 +++++++++++++
 tb/tb_sram_bus_arbiter.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared CPU-side bus definitions: requester ownership tags, transfer sizes and the request payload.
package cpu_bus_pkg;

    typedef enum logic {
        OWNER_INST = 1'b0,
        OWNER_DATA = 1'b1
    } owner_e;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/owner_fifo.sv
// In-order record of which requester owns each accepted-but-unanswered downstream request.
module owner_fifo
    import cpu_bus_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   i_push,
    input  owner_e i_din,
    input  logic   i_pop,
    output logic   o_full,
    output logic   o_empty,
    output owner_e o_head
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    owner_e        r_mem [DEPTH];

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= ptr_next(r_wr_ptr);
            if (i_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like port between instruction fetch and data access: data-first priority with a
// starvation guard, grant locking across address stalls, and in-order response routing.
module sram_bus_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned STARVE_LIMIT    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata,
    output logic        orphan_err
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    logic          r_lock;
    owner_e        r_lock_owner;
    logic [SW-1:0] r_starve_cnt;
    logic          r_orphan_err;

    owner_e   w_sel;
    logic     w_sel_req;
    logic     w_full;
    logic     w_empty;
    owner_e   w_head;
    logic     w_accept;
    logic     w_stall;
    logic     w_pop;
    bus_req_t w_inst_bus;
    bus_req_t w_data_bus;
    bus_req_t w_m_bus;

    // A stalled grant keeps the port; otherwise a saturated starvation count forces one inst grant.
    always_comb begin
        w_sel = OWNER_INST;
        if (r_lock) begin
            w_sel = r_lock_owner;
        end else if (inst_req && data_req && (r_starve_cnt == SW'(STARVE_LIMIT))) begin
            w_sel = OWNER_INST;
        end else if (data_req) begin
            w_sel = OWNER_DATA;
        end else begin
            w_sel = OWNER_INST;
        end
    end

    assign w_sel_req  = (w_sel == OWNER_DATA) ? data_req : inst_req;
    assign m_req      = w_sel_req && !w_full;
    assign w_accept   = m_req && m_addr_ok;
    assign w_stall    = m_req && !m_addr_ok;
    assign w_pop      = m_data_ok && !w_empty;

    assign w_inst_bus = '{wr: inst_wr, size: inst_size, addr: inst_addr, wdata: inst_wdata};
    assign w_data_bus = '{wr: data_wr, size: data_size, addr: data_addr, wdata: data_wdata};
    assign w_m_bus    = !m_req ? '0 : ((w_sel == OWNER_DATA) ? w_data_bus : w_inst_bus);

    assign m_wr    = w_m_bus.wr;
    assign m_size  = w_m_bus.size;
    assign m_addr  = w_m_bus.addr;
    assign m_wdata = w_m_bus.wdata;

    assign inst_addr_ok = w_accept && (w_sel == OWNER_INST);
    assign data_addr_ok = w_accept && (w_sel == OWNER_DATA);
    assign inst_data_ok = w_pop && (w_head == OWNER_INST);
    assign data_data_ok = w_pop && (w_head == OWNER_DATA);
    assign inst_rdata   = m_rdata;
    assign data_rdata   = m_rdata;
    assign orphan_err   = r_orphan_err;

    owner_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_owner_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_accept),
        .i_din   (w_sel),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lock       <= 1'b0;
            r_lock_owner <= OWNER_INST;
            r_starve_cnt <= '0;
            r_orphan_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_lock <= 1'b0;
            end else if (w_stall) begin
                r_lock       <= 1'b1;
                r_lock_owner <= w_sel;
            end else begin
                r_lock <= 1'b0;
            end

            if (!inst_req) begin
                r_starve_cnt <= '0;
            end else if (w_accept && (w_sel == OWNER_INST)) begin
                r_starve_cnt <= '0;
            end else if (w_accept && (r_starve_cnt != SW'(STARVE_LIMIT))) begin
                r_starve_cnt <= r_starve_cnt + SW'(1);
            end

            if (m_data_ok && w_empty) begin
                r_orphan_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Self-checking bench for sram_bus_arbiter: directed scenarios plus randomized traffic against a
// queue-based reference model of the arbitration and response-routing rules.
module tb_sram_bus_arbiter;
    import cpu_bus_pkg::*;

    localparam int unsigned MAXO   = 2;
    localparam int unsigned SLIMIT = 4;

    logic        clk;
    logic        rst;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        m_req, m_wr;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata;
    logic        m_addr_ok, m_data_ok;
    logic [31:0] m_rdata;
    logic        orphan_err;

    int checks = 0;
    int errors = 0;

    // Reference model state: owners of outstanding requests in acceptance order.
    bit md_lock;
    bit md_owner;
    int md_starve;
    bit md_orphan;
    bit owner_q[$];

    // Expected values for the current cycle.
    bit          e_sel, e_mreq, e_acc, e_stall, e_pop;
    bit          e_iaok, e_daok, e_idok, e_ddok;
    logic [66:0] e_bus;

    sram_bus_arbiter #(
        .MAX_OUTSTANDING (MAXO),
        .STARVE_LIMIT    (SLIMIT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_addr    (inst_addr),
        .inst_wdata   (inst_wdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .m_req        (m_req),
        .m_wr         (m_wr),
        .m_size       (m_size),
        .m_addr       (m_addr),
        .m_wdata      (m_wdata),
        .m_addr_ok    (m_addr_ok),
        .m_data_ok    (m_data_ok),
        .m_rdata      (m_rdata),
        .orphan_err   (orphan_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_idle();
        inst_req = 0; inst_wr = 0; inst_size = 2'b00; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 2'b00; data_addr = 0; data_wdata = 0;
        m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
    endtask

    task automatic model_reset();
        md_lock = 0; md_owner = 0; md_starve = 0; md_orphan = 0;
        owner_q.delete();
    endtask

    // Expected combinational behaviour for the inputs currently driven.
    task automatic eval();
        if (md_lock)                                        e_sel = md_owner;
        else if (inst_req && data_req && md_starve == SLIMIT) e_sel = 0;
        else if (data_req)                                  e_sel = 1;
        else                                                e_sel = 0;
        e_mreq  = (e_sel ? data_req : inst_req) && (owner_q.size() < MAXO);
        e_acc   = e_mreq && m_addr_ok;
        e_stall = e_mreq && !m_addr_ok;
        e_iaok  = e_acc && !e_sel;
        e_daok  = e_acc && e_sel;
        e_pop   = m_data_ok && (owner_q.size() > 0);
        e_idok  = e_pop && (owner_q[0] == 0);
        e_ddok  = e_pop && (owner_q[0] == 1);
        if (!e_mreq)    e_bus = '0;
        else if (e_sel) e_bus = {data_wr, data_size, data_addr, data_wdata};
        else            e_bus = {inst_wr, inst_size, inst_addr, inst_wdata};
    endtask

    // Advance the model across the next rising edge and return to the following falling edge.
    task automatic tick();
        if (e_pop) void'(owner_q.pop_front());
        if (e_acc) owner_q.push_back(e_sel);
        if (m_data_ok && !e_pop) md_orphan = 1;
        if (e_acc)        md_lock = 0;
        else if (e_stall) begin md_lock = 1; md_owner = e_sel; end
        else              md_lock = 0;
        if (!inst_req)                         md_starve = 0;
        else if (e_acc && !e_sel)              md_starve = 0;
        else if (e_acc && md_starve < SLIMIT)  md_starve++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        set_idle();
        m_rdata = 32'h1234_5678;
        rst = 0;
        model_reset();
        #1;
        checks++;
        if ({m_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, orphan_err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b exp=000000",
                     {m_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, orphan_err});
        end
        checks++;
        if ({m_wr, m_size, m_addr, m_wdata} !== 67'b0) begin
            errors++;
            $display("FAIL reset_bus got=%h exp=0", {m_wr, m_size, m_addr, m_wdata});
        end
        checks++;
        if (inst_rdata !== 32'h1234_5678 || data_rdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL reset_rdata got=%h/%h exp=12345678", inst_rdata, data_rdata);
        end
        @(negedge clk);
        rst = 1;
        @(negedge clk);
    endtask

    task automatic test_inst_fetch();
        set_idle();
        inst_req = 1; inst_addr = 32'hbfc0_0000; inst_size = SIZE_WORD; m_addr_ok = 1;
        eval(); #1;
        checks++;
        if (m_addr !== 32'hbfc0_0000 || inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0) begin
            errors++;
            $display("FAIL fetch_grant got addr=%h iaok=%b daok=%b exp addr=bfc00000 iaok=1 daok=0",
                     m_addr, inst_addr_ok, data_addr_ok);
        end
        tick();
        set_idle(); eval(); tick();
        m_data_ok = 1; m_rdata = 32'h3c1d_0000;
        eval(); #1;
        checks++;
        if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0 || inst_rdata !== 32'h3c1d_0000) begin
            errors++;
            $display("FAIL fetch_resp got idok=%b ddok=%b rdata=%h exp 1 0 3c1d0000",
                     inst_data_ok, data_data_ok, inst_rdata);
        end
        tick();
        set_idle();
    endtask

    task automatic test_priority();
        set_idle();
        inst_req = 1; inst_addr = 32'h0000_1000;
        data_req = 1; data_addr = 32'h8000_0040;
        m_addr_ok = 1;
        eval(); #1;
        checks++;
        if (m_addr !== 32'h8000_0040 || data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0) begin
            errors++;
            $display("FAIL prio_first got addr=%h daok=%b iaok=%b exp 80000040 1 0",
                     m_addr, data_addr_ok, inst_addr_ok);
        end
        tick();
        data_req = 0;
        eval(); #1;
        checks++;
        if (m_addr !== 32'h0000_1000 || inst_addr_ok !== 1'b1) begin
            errors++;
            $display("FAIL prio_second got addr=%h iaok=%b exp 00001000 1", m_addr, inst_addr_ok);
        end
        tick();
        set_idle(); m_data_ok = 1;
        eval(); #1;
        checks++;
        if ({inst_data_ok, data_data_ok} !== 2'b01) begin
            errors++;
            $display("FAIL prio_resp_d got i/d=%b exp 01", {inst_data_ok, data_data_ok});
        end
        tick();
        eval(); #1;
        checks++;
        if ({inst_data_ok, data_data_ok} !== 2'b10) begin
            errors++;
            $display("FAIL prio_resp_i got i/d=%b exp 10", {inst_data_ok, data_data_ok});
        end
        tick();
        set_idle(); eval(); tick();
    endtask

    task automatic test_starvation();
        int exp_grant [11] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1};
        int got;
        set_idle();
        for (int c = 0; c < 11; c++) begin
            inst_req = 1; inst_addr = 32'h100 + 32'(c * 4);
            data_req = 1; data_addr = 32'h200 + 32'(c * 4);
            m_addr_ok = 1;
            m_data_ok = (owner_q.size() > 0);
            eval(); #1;
            got = data_addr_ok ? 1 : (inst_addr_ok ? 0 : 2);
            checks++;
            if (got !== exp_grant[c]) begin
                errors++;
                $display("FAIL starve_grant cyc=%0d got=%0d exp=%0d (1=data 0=inst)", c, got, exp_grant[c]);
            end
            tick();
        end
        set_idle();
        for (int c = 0; c < 4 && owner_q.size() > 0; c++) begin
            m_data_ok = 1; eval(); tick();
        end
        set_idle(); eval(); tick();
    endtask

    task automatic test_stall_lock();
        set_idle();
        inst_addr = 32'h0000_2000; data_addr = 32'h8000_1000;
        for (int c = 0; c < 4; c++) begin
            inst_req  = 1;
            data_req  = (c >= 1);
            m_addr_ok = (c == 3);
            eval(); #1;
            checks++;
            if (m_req !== 1'b1 || m_addr !== 32'h0000_2000 || data_addr_ok !== 1'b0
                || inst_addr_ok !== (c == 3)) begin
                errors++;
                $display("FAIL lock_hold cyc=%0d got req=%b addr=%h iaok=%b daok=%b exp 1 00002000 %0d 0",
                         c, m_req, m_addr, inst_addr_ok, data_addr_ok, (c == 3));
            end
            tick();
        end
        inst_req = 0;
        eval(); #1;
        checks++;
        if (data_addr_ok !== 1'b1 || m_addr !== 32'h8000_1000) begin
            errors++;
            $display("FAIL lock_release got daok=%b addr=%h exp 1 80001000", data_addr_ok, m_addr);
        end
        tick();
        set_idle();
        for (int c = 0; c < 2; c++) begin
            m_data_ok = 1; eval(); #1;
            checks++;
            if ({inst_data_ok, data_data_ok} !== (c == 0 ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL lock_resp cyc=%0d got i/d=%b exp %b", c,
                         {inst_data_ok, data_data_ok}, (c == 0 ? 2'b10 : 2'b01));
            end
            tick();
        end
        set_idle(); eval(); tick();
    endtask

    task automatic test_full();
        set_idle();
        data_req = 1; m_addr_ok = 1;
        for (int c = 0; c < 5; c++) begin
            data_addr = 32'h3000 + 32'(c * 4);
            m_data_ok = (c == 3);
            eval(); #1;
            checks++;
            if (m_req !== (c != 2 && c != 3)) begin
                errors++;
                $display("FAIL full_mreq cyc=%0d got=%b exp=%0d", c, m_req, (c != 2 && c != 3));
            end
            if (c == 3) begin
                checks++;
                if (data_data_ok !== 1'b1) begin
                    errors++;
                    $display("FAIL full_pop got ddok=%b exp 1", data_data_ok);
                end
            end
            tick();
        end
        set_idle();
        for (int c = 0; c < 4 && owner_q.size() > 0; c++) begin
            m_data_ok = 1; eval(); tick();
        end
        set_idle(); eval(); tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            inst_req   = ($urandom_range(0, 2) != 0);
            inst_wr    = 0;
            inst_size  = SIZE_WORD;
            inst_addr  = $urandom;
            inst_wdata = $urandom;
            data_req   = ($urandom_range(0, 1) != 0);
            data_wr    = ($urandom_range(0, 1) != 0);
            data_size  = 2'($urandom_range(0, 2));
            data_addr  = $urandom;
            data_wdata = $urandom;
            m_addr_ok  = ($urandom_range(0, 9) < 7);
            m_data_ok  = (owner_q.size() > 0) && ($urandom_range(0, 1) != 0);
            m_rdata    = $urandom;
            eval(); #1;
            checks++;
            if ({m_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, orphan_err}
                !== {e_mreq, e_iaok, e_daok, e_idok, e_ddok, md_orphan}) begin
                errors++;
                $display("FAIL rand_ctrl cyc=%0d got=%b exp=%b", c,
                         {m_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, orphan_err},
                         {e_mreq, e_iaok, e_daok, e_idok, e_ddok, md_orphan});
            end
            checks++;
            if ({m_wr, m_size, m_addr, m_wdata} !== e_bus) begin
                errors++;
                $display("FAIL rand_bus cyc=%0d got=%h exp=%h", c, {m_wr, m_size, m_addr, m_wdata}, e_bus);
            end
            checks++;
            if (inst_rdata !== m_rdata || data_rdata !== m_rdata) begin
                errors++;
                $display("FAIL rand_rdata cyc=%0d got=%h/%h exp=%h", c, inst_rdata, data_rdata, m_rdata);
            end
            tick();
        end
        set_idle();
        for (int c = 0; c < 4 && owner_q.size() > 0; c++) begin
            m_data_ok = 1; eval(); tick();
        end
        set_idle(); eval(); tick();
    endtask

    task automatic test_orphan_reset();
        set_idle();
        m_data_ok = 1;
        eval(); #1;
        checks++;
        if ({inst_data_ok, data_data_ok} !== 2'b00) begin
            errors++;
            $display("FAIL orphan_dok got=%b exp=00", {inst_data_ok, data_data_ok});
        end
        tick();
        set_idle(); eval(); #1;
        checks++;
        if (orphan_err !== 1'b1) begin
            errors++;
            $display("FAIL orphan_set got=%b exp=1", orphan_err);
        end
        tick();
        inst_req = 1; inst_addr = 32'h4000; m_addr_ok = 1;
        eval(); tick();
        set_idle();
        #2 rst = 0;
        model_reset();
        #1;
        checks++;
        if ({m_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, orphan_err} !== 6'b0) begin
            errors++;
            $display("FAIL async_reset got=%b exp=000000",
                     {m_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, orphan_err});
        end
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        m_data_ok = 1;
        eval(); #1;
        checks++;
        if ({inst_data_ok, data_data_ok} !== 2'b00) begin
            errors++;
            $display("FAIL inflight_dok got=%b exp=00", {inst_data_ok, data_data_ok});
        end
        tick();
        set_idle(); eval(); #1;
        checks++;
        if (orphan_err !== 1'b1) begin
            errors++;
            $display("FAIL inflight_orphan got=%b exp=1", orphan_err);
        end
        tick();
    endtask

    initial begin
        set_idle();
        rst = 0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_inst_fetch();
        test_priority();
        test_starvation();
        test_stall_lock();
        test_full();
        test_random();
        test_orphan_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
